// File: rtl/laser_point_feeder_if.sv
// Host point stream, engine drive/result and result-port signals of the laser point feeder.
interface laser_point_feeder_if;
   logic       IN_VALID;
   logic       IN_READY;
   logic [3:0] IN_X;
   logic [3:0] IN_Y;
   logic       ENG_RST;
   logic [3:0] X;
   logic [3:0] Y;
   logic       DONE;
   logic [3:0] C1X;
   logic [3:0] C1Y;
   logic [3:0] C2X;
   logic [3:0] C2Y;
   logic       RES_VALID;
   logic       RES_READY;
   logic [3:0] RES_C1X;
   logic [3:0] RES_C1Y;
   logic [3:0] RES_C2X;
   logic [3:0] RES_C2Y;
   logic       ERR;

   // Handshakes: a point moves on a rising edge with IN_VALID && IN_READY; a result
   // moves on a rising edge with RES_VALID && RES_READY. A raised valid stays up with
   // stable data until that transfer edge.
   modport slave (
      input  IN_VALID, IN_X, IN_Y, DONE, C1X, C1Y, C2X, C2Y, RES_READY,
      output IN_READY, ENG_RST, X, Y, RES_VALID, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, ERR
   );

   modport master (
      output IN_VALID, IN_X, IN_Y, DONE, C1X, C1Y, C2X, C2Y, RES_READY,
      input  IN_READY, ENG_RST, X, Y, RES_VALID, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, ERR
   );
endinterface

// File: rtl/laser_point_feeder.sv
// Point feeder for the two-circle laser coverage engine: buffers host points into two
// ping-pong banks, streams a full bank to the engine, and holds the engine's result.
module laser_point_feeder #(
   parameter int NPTS    = 40,
   parameter int TIMEOUT = 16384
) (
   input  logic                CLK,
   input  logic                RST,
   laser_point_feeder_if.slave bus,
   output logic [1:0]          dbg_state_o
);

   // Counters must be able to hold NPTS itself (read side uses it as "last point shown").
   localparam int CW = $clog2(NPTS + 1);
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_HOLD   = 2'd0,
      S_STREAM = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      full_q, full_d;
   logic            wbank_q, wbank_d;
   logic            rbank_q, rbank_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [CW-1:0]   rcnt_q, rcnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [3:0]      x_q, x_d;
   logic [3:0]      y_q, y_d;
   logic            eng_rst_q, eng_rst_d;
   logic            res_valid_q, res_valid_d;
   logic [15:0]     res_q, res_d;
   logic            err_q, err_d;

   logic            in_ready;
   logic            wr_fire;
   logic            wr_last;

   // Point storage: bank index, then slot; not reset because full flags gate every read.
   logic [7:0]      bank_mem [0:1][0:NPTS-1];

   assign in_ready = !full_q[wbank_q] && !RST;
   assign wr_fire  = bus.IN_VALID && in_ready;
   assign wr_last  = (wcnt_q == CW'(NPTS - 1));

   // Capture accepted host points into the bank currently being filled.
   always_ff @(posedge CLK) begin
      if (wr_fire) begin
         bank_mem[wbank_q][wcnt_q] <= {bus.IN_X, bus.IN_Y};
      end
   end

   // Next-state and datapath decisions for the write side, read FSM and result slot.
   always_comb begin
      state_d     = state_q;
      full_d      = full_q;
      wbank_d     = wbank_q;
      rbank_d     = rbank_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      tmr_d       = tmr_q;
      x_d         = x_q;
      y_d         = y_q;
      eng_rst_d   = eng_rst_q;
      res_valid_d = res_valid_q;
      res_d       = res_q;
      err_d       = 1'b0;

      // Result slot drains on its handshake; a new result can only arrive when it is empty.
      if (res_valid_q && bus.RES_READY) begin
         res_valid_d = 1'b0;
      end

      case (state_q)
         S_HOLD: begin
            eng_rst_d = 1'b1;
            if (full_q[rbank_q] && (!res_valid_q || bus.RES_READY)) begin
               eng_rst_d  = 1'b0;
               {x_d, y_d} = bank_mem[rbank_q][0];
               rcnt_d     = CW'(1);
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            if (rcnt_q == CW'(NPTS)) begin
               // Point NPTS-1 has just been sampled: release the bank.
               x_d             = 4'd0;
               y_d             = 4'd0;
               full_d[rbank_q] = 1'b0;
               rbank_d         = ~rbank_q;
               tmr_d           = '0;
               state_d         = S_WAIT;
            end else begin
               {x_d, y_d} = bank_mem[rbank_q][rcnt_q];
               rcnt_d     = rcnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            if (bus.DONE) begin
               // Engine outputs vanish once ENG_RST rises, so latch them right here.
               res_d       = {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y};
               res_valid_d = 1'b1;
               eng_rst_d   = 1'b1;
               state_d     = S_HOLD;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
               err_d     = 1'b1;
               eng_rst_d = 1'b1;
               state_d   = S_HOLD;
            end else if (tmr_q != {TW{1'b1}}) begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: begin
            eng_rst_d = 1'b1;
            state_d   = S_HOLD;
         end
      endcase

      // Write side never touches the bank being released (it needs !full, release needs full).
      if (wr_fire) begin
         if (wr_last) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
            wcnt_d          = '0;
         end else begin
            wcnt_d = wcnt_q + CW'(1);
         end
      end
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_HOLD;
         full_q      <= 2'b00;
         wbank_q     <= 1'b0;
         rbank_q     <= 1'b0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         tmr_q       <= '0;
         x_q         <= 4'd0;
         y_q         <= 4'd0;
         eng_rst_q   <= 1'b1;
         res_valid_q <= 1'b0;
         res_q       <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         full_q      <= full_d;
         wbank_q     <= wbank_d;
         rbank_q     <= rbank_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         tmr_q       <= tmr_d;
         x_q         <= x_d;
         y_q         <= y_d;
         eng_rst_q   <= eng_rst_d;
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
         err_q       <= err_d;
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.ENG_RST   = eng_rst_q;
   assign bus.X         = x_q;
   assign bus.Y         = y_q;
   assign bus.RES_VALID = res_valid_q;
   assign bus.RES_C1X   = res_q[15:12];
   assign bus.RES_C1Y   = res_q[11:8];
   assign bus.RES_C2X   = res_q[7:4];
   assign bus.RES_C2Y   = res_q[3:0];
   assign bus.ERR       = err_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Directed bench for laser_point_feeder with point and result scoreboards.
module tb_laser_point_feeder;

   localparam int NPTS = 40;
   localparam int TMO  = 64;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] dbg_state;

   laser_point_feeder_if bus ();

   laser_point_feeder #(
      .NPTS    (NPTS),
      .TIMEOUT (TMO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Scoreboard state
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q [$];
   logic [15:0] res_q [$];
   int          stream_cnt = 0;
   int          sets_done  = 0;
   int          err_cnt    = 0;
   logic [15:0] res_obs;

   assign res_obs = {bus.RES_C1X, bus.RES_C1Y, bus.RES_C2X, bus.RES_C2Y};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Engine-side monitor: each cycle after ENG_RST falls must show the next queued point,
   // followed by one cycle of zeros.
   always @(negedge CLK) begin
      if (RST) begin
         stream_cnt = 0;
      end else begin
         if (bus.ERR) err_cnt++;
         if (bus.ENG_RST) begin
            stream_cnt = 0;
         end else if (stream_cnt < NPTS) begin
            if (exp_q.size() == 0)
               check("stream_q_empty", 32'(exp_q.size()), 32'd1);
            else
               check($sformatf("stream_pt%0d", stream_cnt), {24'd0, bus.X, bus.Y}, {24'd0, exp_q.pop_front()});
            stream_cnt++;
         end else if (stream_cnt == NPTS) begin
            check("stream_tail_zero", {24'd0, bus.X, bus.Y}, 32'd0);
            stream_cnt++;
            sets_done++;
         end
      end
   end

   // Driver tasks: every step of the sequence lands 1 time unit after a falling edge.
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic write_point(input logic [3:0] x, input logic [3:0] y, output int waited);
      bus.IN_VALID = 1'b1;
      bus.IN_X     = x;
      bus.IN_Y     = y;
      waited       = 0;
      while (!bus.IN_READY && waited < 500) begin
         tick();
         waited++;
      end
      if (!bus.IN_READY) begin
         check("in_ready_timeout", {31'd0, bus.IN_READY}, 32'd1);
         bus.IN_VALID = 1'b0;
         return;
      end
      tick();
      exp_q.push_back({x, y});
      bus.IN_VALID = 1'b0;
   endtask

   task automatic write_points(input int n, input int mode, output int total_wait);
      int w;
      total_wait = 0;
      for (int i = 0; i < n; i++) begin
         logic [3:0] x;
         logic [3:0] y;
         if (mode == 0) begin
            x = 4'(i % 16);
            y = 4'((i * 3) % 16);
         end else begin
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
         end
         write_point(x, y, w);
         total_wait += w;
      end
   endtask

   task automatic wait_sets(input int target);
      int n = 0;
      while (sets_done < target && n < 300) begin
         tick();
         n++;
      end
      check("sets_done", sets_done, target);
   endtask

   task automatic drive_done(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      bus.DONE = 1'b1;
      bus.C1X  = a;
      bus.C1Y  = b;
      bus.C2X  = c;
      bus.C2Y  = d;
      res_q.push_back({a, b, c, d});
      tick();
      bus.DONE = 1'b0;
      bus.C1X  = 4'd0;
      bus.C1Y  = 4'd0;
      bus.C2X  = 4'd0;
      bus.C2Y  = 4'd0;
   endtask

   task automatic accept_result();
      bus.RES_READY = 1'b1;
      check("res_valid_at_accept", {31'd0, bus.RES_VALID}, 32'd1);
      if (res_q.size() == 0)
         check("res_q_empty", 32'(res_q.size()), 32'd1);
      else
         check("res_data", {16'd0, res_obs}, {16'd0, res_q.pop_front()});
      tick();
      bus.RES_READY = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_eng_rst"}, {31'd0, bus.ENG_RST}, 32'd1);
      check({tag, "_xy"}, {24'd0, bus.X, bus.Y}, 32'd0);
      check({tag, "_in_ready"}, {31'd0, bus.IN_READY}, 32'd0);
      check({tag, "_res_valid"}, {31'd0, bus.RES_VALID}, 32'd0);
      check({tag, "_res_data"}, {16'd0, res_obs}, 32'd0);
      check({tag, "_err"}, {31'd0, bus.ERR}, 32'd0);
      check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   // Directed sequence
   initial begin
      int w;
      int w2;
      int k;
      RST           = 1'b1;
      bus.IN_VALID  = 1'b0;
      bus.IN_X      = 4'd0;
      bus.IN_Y      = 4'd0;
      bus.DONE      = 1'b0;
      bus.C1X       = 4'd0;
      bus.C1Y       = 4'd0;
      bus.C2X       = 4'd0;
      bus.C2Y       = 4'd0;
      bus.RES_READY = 1'b0;
      tick();
      tick();
      check_reset("rst0");
      RST = 1'b0;
      tick();
      check("ready_after_rst", {31'd0, bus.IN_READY}, 32'd1);

      // Single set, no gaps: engine released exactly one edge after the 40th transfer.
      write_points(NPTS, 0, w);
      check("set0_no_wait", w, 0);
      check("eng_rst_at_last_write", {31'd0, bus.ENG_RST}, 32'd1);
      tick();
      check("eng_rst_fell", {31'd0, bus.ENG_RST}, 32'd0);
      check("state_stream", {30'd0, dbg_state}, 32'd1);
      check("in_ready_streaming", {31'd0, bus.IN_READY}, 32'd1);
      wait_sets(1);

      // Result capture with the consumer stalled.
      drive_done(4'd3, 4'd4, 4'd10, 4'd9);
      check("res_valid_rise", {31'd0, bus.RES_VALID}, 32'd1);
      check("eng_rst_after_done", {31'd0, bus.ENG_RST}, 32'd1);
      check("res_first", {16'd0, res_obs}, {16'd0, res_q[0]});
      for (int i = 0; i < 5; i++) begin
         tick();
         check("res_hold_valid", {31'd0, bus.RES_VALID}, 32'd1);
         check("res_hold_data", {16'd0, res_obs}, {16'd0, res_q[0]});
      end
      accept_result();
      check("res_valid_cleared", {31'd0, bus.RES_VALID}, 32'd0);

      // DONE outside WAIT_DONE must not create a result.
      bus.DONE = 1'b1;
      bus.C1X  = 4'hf;
      tick();
      bus.DONE = 1'b0;
      bus.C1X  = 4'd0;
      check("stray_done_ignored", {31'd0, bus.RES_VALID}, 32'd0);
      check("stray_done_state", {30'd0, dbg_state}, 32'd0);

      // Ping-pong back-pressure from a fresh reset: 80 points back to back.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      write_points(NPTS, 1, w);
      write_points(NPTS, 1, w2);
      check("pingpong_no_wait", w + w2, 0);
      check("ready_low_after_80", {31'd0, bus.IN_READY}, 32'd0);
      tick();
      check("ready_back_after_stream", {31'd0, bus.IN_READY}, 32'd1);
      check("state_wait_done", {30'd0, dbg_state}, 32'd2);
      check("bank0_streamed", sets_done, 2);

      // Timeout: no DONE, ERR fires TIMEOUT cycles after WAIT_DONE entry.
      k = 0;
      while (!bus.ERR && k < 200) begin
         tick();
         k++;
      end
      check("err_latency", k, TMO);
      check("eng_rst_on_err", {31'd0, bus.ENG_RST}, 32'd1);
      check("no_result_on_err", {31'd0, bus.RES_VALID}, 32'd0);
      tick();
      check("err_one_cycle", {31'd0, bus.ERR}, 32'd0);
      check("next_set_streams", {31'd0, bus.ENG_RST}, 32'd0);
      wait_sets(3);

      // Result-slot stall with two full sets buffered.
      write_points(NPTS, 1, w);
      check("stall_fill0_no_wait", w, 0);
      drive_done(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd7, 4'd1);
      check("stall_res_valid", {31'd0, bus.RES_VALID}, 32'd1);
      write_points(NPTS, 1, w);
      check("stall_fill1_no_wait", w, 0);
      check("stall_both_full", {31'd0, bus.IN_READY}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_eng_rst_held", {31'd0, bus.ENG_RST}, 32'd1);
      end
      accept_result();
      check("stall_release", {31'd0, bus.ENG_RST}, 32'd0);
      check("stall_res_cleared", {31'd0, bus.RES_VALID}, 32'd0);

      // Mid-operation reset while point 17 is on X/Y.
      for (int i = 0; i < 17; i++) tick();
      RST = 1'b1;
      #1;
      check_reset("rst_mid");
      exp_q.delete();
      tick();
      RST = 1'b0;
      tick();
      write_points(NPTS - 1, 1, w);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("partial_set_held", {31'd0, bus.ENG_RST}, 32'd1);
      end
      write_points(1, 1, w);
      check("full_after_reset_held", {31'd0, bus.ENG_RST}, 32'd1);
      tick();
      check("fresh_set_streams", {31'd0, bus.ENG_RST}, 32'd0);
      wait_sets(4);
      drive_done(4'd12, 4'd5, 4'd0, 4'd14);
      accept_result();
      check("final_res_cleared", {31'd0, bus.RES_VALID}, 32'd0);

      check("err_pulse_count", err_cnt, 1);
      check("points_all_streamed", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
